// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator for CVT/VESA-style video modes.
// Internal counters (h, v) walk the full raster; each enabled cycle decodes
// sync, display enable and strobes from the current (h, v) and registers them
// together, so every output has the same one-clock latency.
//
// Ports:
//   clk_in       in   1    system clock
//   reset        in   1    synchronous, active-high reset (priority over pix_en)
//   pix_en       in   1    pixel clock enable; raster advances only when high
//   h_sync       out  1    horizontal sync, active level H_POL
//   v_sync       out  1    vertical sync, active level V_POL (line based)
//   display_en   out  1    high while the output pixel is in the active area
//   h_count      out  CW   horizontal coordinate of the output pixel
//   v_count      out  CW   vertical coordinate of the output pixel
//   line_start   out  1    one-clock pulse when h_count becomes 0
//   frame_start  out  1    one-clock pulse when h_count and v_count become 0
//   frame_count  out  FCW  completed-frame counter, wraps modulo 2^FCW
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   CW       = 12,
    parameter int   FCW      = 16
) (
    input  logic           clk_in,
    input  logic           reset,
    input  logic           pix_en,
    output logic           h_sync,
    output logic           v_sync,
    output logic           display_en,
    output logic [CW-1:0]  h_count,
    output logic [CW-1:0]  v_count,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region boundaries are one bit wider than the counters so that an end
    // boundary equal to 2^CW (possible when H_TOTAL-1 fills CW bits) is exact.
    localparam logic [CW:0] H_ACT_END = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] HS_START  = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END    = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_ACT_END = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] VS_START  = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END    = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Raster position that the next enabled cycle will emit.
    logic [CW-1:0] h_p0;
    logic [CW-1:0] v_p0;
    // Set once the first frame after reset has started; the first frame_start
    // after reset must not count a completed frame.
    logic          first_done;

    logic [CW:0]   h_ext;
    logic [CW:0]   v_ext;
    logic          de_p0;
    logic          hs_p0;
    logic          vs_p0;
    logic          ls_p0;
    logic          fs_p0;
    logic          h_wrap;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;

    // Stage p0: decode outputs and next position from the current (h, v).
    always_comb begin
        h_ext  = {1'b0, h_p0};
        v_ext  = {1'b0, v_p0};
        de_p0  = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        hs_p0  = ((h_ext >= HS_START) && (h_ext < HS_END)) ? H_POL : ~H_POL;
        vs_p0  = ((v_ext >= VS_START) && (v_ext < VS_END)) ? V_POL : ~V_POL;
        ls_p0  = (h_p0 == '0);
        fs_p0  = (h_p0 == '0) && (v_p0 == '0);
        h_wrap = (h_p0 == H_LAST);
        h_next = h_wrap ? '0 : h_p0 + CW'(1);
        v_next = v_p0;
        if (h_wrap) begin
            v_next = (v_p0 == V_LAST) ? '0 : v_p0 + CW'(1);
        end
    end

    // Stage p1: register the decoded outputs and advance the raster.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            h_p0        <= '0;
            v_p0        <= '0;
            first_done  <= 1'b0;
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            display_en  <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            // Strobes are single-cycle and never appear in a disabled cycle.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                h_p0        <= h_next;
                v_p0        <= v_next;
                h_sync      <= hs_p0;
                v_sync      <= vs_p0;
                display_en  <= de_p0;
                h_count     <= h_p0;
                v_count     <= v_p0;
                line_start  <= ls_p0;
                frame_start <= fs_p0;
                if (fs_p0) begin
                    first_done <= 1'b1;
                    if (first_done) begin
                        frame_count <= frame_count + FCW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Scoreboard bench for vga_timing_gen. Two instances share clock, reset and
// pix_en: a small active-low mode (16x11 raster, CW=5) and a small active-high
// mode (9x6 raster, CW=4, FCW=2). The stimulus process steps a reference model
// per issued input vector and queues the expected outputs; the monitor pops
// and compares them against both DUTs, plus hand-computed sync/enable windows,
// line/frame periods, strobe widths and the FCW=2 frame_count sequence.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic pix_en;

    logic       hs_a, vs_a, de_a, ls_a, fs_a;
    logic [4:0] hc_a, vc_a;
    logic [15:0] fc_a;

    logic       hs_b, vs_b, de_b, ls_b, fs_b;
    logic [3:0] hc_b, vc_b;
    logic [1:0] fc_b;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b0), .V_POL(1'b0), .CW(5), .FCW(16)
    ) dut_a (
        .clk_in(clk), .reset(reset), .pix_en(pix_en),
        .h_sync(hs_a), .v_sync(vs_a), .display_en(de_a),
        .h_count(hc_a), .v_count(vc_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(4), .FCW(2)
    ) dut_b (
        .clk_in(clk), .reset(reset), .pix_en(pix_en),
        .h_sync(hs_b), .v_sync(vs_b), .display_en(de_b),
        .h_count(hc_b), .v_count(vc_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    typedef struct {
        int h; int v;
        bit live; bit seen;
        bit hs; bit vs; bit de; bit ls; bit fs;
        int hc; int vc; int fc;
    } mstate_t;

    typedef struct {
        longint  cyc;
        bit      rst;
        int      mode;
        mstate_t a;
        mstate_t b;
    } ent_t;

    ent_t    q[$];
    mstate_t ma, mb;
    longint  cyc = 0;
    int      mode = 0;
    int      n_assert = 0;
    int      n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference raster model: one step per clock edge.
    function automatic mstate_t step(mstate_t s, bit rst, bit en,
                                     int ha, int hf, int hw, int hb,
                                     int va, int vf, int vw, int vb,
                                     bit hp, bit vp, int fcw);
        mstate_t n = s;
        int ht = ha + hf + hw + hb;
        int vt = va + vf + vw + vb;
        if (rst) begin
            n.h = 0; n.v = 0; n.live = 0; n.seen = 0;
            n.hs = !hp; n.vs = !vp; n.de = 0; n.ls = 0; n.fs = 0;
            n.hc = 0; n.vc = 0; n.fc = 0;
            return n;
        end
        n.ls = 0;
        n.fs = 0;
        if (!en) return n;
        n.live = 1;
        n.hc = s.h;
        n.vc = s.v;
        n.de = (s.h < ha) && (s.v < va);
        n.hs = (s.h >= ha + hf && s.h < ha + hf + hw) ? hp : !hp;
        n.vs = (s.v >= va + vf && s.v < va + vf + vw) ? vp : !vp;
        n.ls = (s.h == 0);
        n.fs = (s.h == 0) && (s.v == 0);
        if (n.fs) begin
            if (s.seen) n.fc = (s.fc + 1) % (1 << fcw);
            n.seen = 1;
        end
        n.h = s.h + 1;
        if (n.h == ht) begin
            n.h = 0;
            n.v = s.v + 1;
            if (n.v == vt) n.v = 0;
        end
        return n;
    endfunction

    task automatic drive(input bit r, input bit e);
        ent_t ne;
        @(posedge clk);
        #1;
        reset  = r;
        pix_en = e;
        ma = step(ma, r, e, 8, 2, 3, 3, 6, 1, 2, 2, 1'b0, 1'b0, 16);
        mb = step(mb, r, e, 5, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 2);
        ne.cyc  = cyc + 1;
        ne.rst  = r;
        ne.mode = mode;
        ne.a    = ma;
        ne.b    = mb;
        q.push_back(ne);
    endtask

    // Monitor-side tracking state.
    int     trk_mode = -1;
    longint ls_last = -1;
    longint fs_last = -1;
    bit     prev_ls_a = 0, prev_fs_a = 0, prev_ls_b = 0, prev_fs_b = 0;
    int     fc_idx = 0;
    int     fc_tbl[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    task automatic check_entry(input ent_t e);
        chk("entry_cycle", cyc, e.cyc);
        // Full comparison against the reference model.
        chk("a_h_sync", hs_a, e.a.hs);
        chk("a_v_sync", vs_a, e.a.vs);
        chk("a_display_en", de_a, e.a.de);
        chk("a_h_count", hc_a, e.a.hc);
        chk("a_v_count", vc_a, e.a.vc);
        chk("a_line_start", ls_a, e.a.ls);
        chk("a_frame_start", fs_a, e.a.fs);
        chk("a_frame_count", fc_a, e.a.fc);
        chk("b_h_sync", hs_b, e.b.hs);
        chk("b_v_sync", vs_b, e.b.vs);
        chk("b_display_en", de_b, e.b.de);
        chk("b_h_count", hc_b, e.b.hc);
        chk("b_v_count", vc_b, e.b.vc);
        chk("b_line_start", ls_b, e.b.ls);
        chk("b_frame_start", fs_b, e.b.fs);
        chk("b_frame_count", fc_b, e.b.fc);
        // Hand-computed windows: A hsync low on h 10..12, vsync low on v 7,8,
        // active 8x6; B hsync high on h 6,7, vsync high on v 4, active 5x3.
        if (e.a.live) begin
            chk("a_hs_window", hs_a, !(e.a.hc >= 10 && e.a.hc <= 12));
            chk("a_vs_window", vs_a, !(e.a.vc == 7 || e.a.vc == 8));
            chk("a_de_window", de_a, (e.a.hc < 8) && (e.a.vc < 6));
        end
        if (e.b.live) begin
            chk("b_hs_window", hs_b, (e.b.hc == 6 || e.b.hc == 7));
            chk("b_vs_window", vs_b, (e.b.vc == 4));
            chk("b_de_window", de_b, (e.b.hc < 5) && (e.b.vc < 3));
        end
        // Strobes are one clock wide.
        if (prev_ls_a) chk("a_ls_width", ls_a, 0);
        if (prev_fs_a) chk("a_fs_width", fs_a, 0);
        if (prev_ls_b) chk("b_ls_width", ls_b, 0);
        if (prev_fs_b) chk("b_fs_width", fs_b, 0);
        prev_ls_a = ls_a; prev_fs_a = fs_a; prev_ls_b = ls_b; prev_fs_b = fs_b;
        // Line/frame periods of instance A: 16 clk per line, 176 per frame
        // with pix_en high; doubled with pix_en toggling.
        if (e.rst || e.mode != trk_mode) begin
            trk_mode = e.mode;
            ls_last  = -1;
            fs_last  = -1;
        end
        if (ls_a) begin
            if (trk_mode != 0 && ls_last >= 0) chk("a_line_period", e.cyc - ls_last, trk_mode);
            ls_last = e.cyc;
        end
        if (fs_a) begin
            if (trk_mode != 0 && fs_last >= 0) chk("a_frame_period", e.cyc - fs_last, trk_mode * 11);
            fs_last = e.cyc;
        end
        // FCW=2 frame_count sequence after each reset.
        if (e.rst) fc_idx = 0;
        if (fs_b && fc_idx < 8) begin
            chk("b_fc_sequence", fc_b, fc_tbl[fc_idx]);
            fc_idx++;
        end
    endtask

    initial begin : monitor
        ent_t e;
        forever begin
            @(posedge clk);
            #3;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                check_entry(e);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        reset  = 1'b1;
        pix_en = 1'b0;
        ma = step(ma, 1'b1, 1'b0, 8, 2, 3, 3, 6, 1, 2, 2, 1'b0, 1'b0, 16);
        mb = step(mb, 1'b1, 1'b0, 5, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 2);

        // Reset holds regardless of pix_en.
        mode = 0;
        repeat (3) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);

        // Continuous enable: two full frames of A, several of B.
        mode = 16;
        repeat (372) drive(1'b0, 1'b1);

        // pix_en toggling 0,1,0,1...
        mode = 32;
        for (int i = 0; i < 1100; i++) drive(1'b0, (i % 2) == 1);

        // Irregular enable pattern.
        mode = 0;
        for (int i = 0; i < 200; i++) drive(1'b0, 1'($urandom_range(0, 1)));

        // Run to A's (13,7) and reset there for one clock with pix_en low.
        k = 0;
        while (!(ma.hc == 13 && ma.vc == 7) && k < 1000) begin
            drive(1'b0, 1'b1);
            k++;
        end
        if (k >= 1000) begin
            n_assert++;
            n_fail++;
            $display("FAIL reach_mid_frame: got %0d steps, required < 1000", k);
        end
        drive(1'b1, 1'b0);
        mode = 16;
        repeat (400) drive(1'b0, 1'b1);
        mode = 0;
        drive(1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #4;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
